// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared types and helpers for the STDP weight-update sequencer
//
// Purpose : sequencer state encoding, per-synapse update decision encoding,
//           and the maximum-weight helper used by the saturation guards.
// Ports   : none (package)
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    UPDATE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    POT,
    DEP
  } upd_t;

  // Largest value a weight counter of width w can hold.
  function automatic int max_weight(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/stdp_update_ctrl_if.sv
// rtl/stdp_update_ctrl_if.sv - spike fabric / weight bank bundle for the STDP sequencer
//
// Purpose : groups the window trigger, spike inputs, weight read-back and the
//           inc/dec pulse outputs that connect the sequencer to its neighbours.
// Ports   : gamma_start, in_spike[NUM_SYN], out_spike, weight_in[NUM_SYN*WEIGHT_W]
//           (driven by master); inc[NUM_SYN], dec[NUM_SYN], busy, done (driven by slave).
interface stdp_update_ctrl_if #(
  parameter int NUM_SYN  = 8,
  parameter int WEIGHT_W = 3
) ();

  logic                        gamma_start;
  logic [NUM_SYN-1:0]          in_spike;
  logic                        out_spike;
  logic [NUM_SYN*WEIGHT_W-1:0] weight_in;
  logic [NUM_SYN-1:0]          inc;
  logic [NUM_SYN-1:0]          dec;
  logic                        busy;
  logic                        done;

  modport master (
    output gamma_start, in_spike, out_spike, weight_in,
    input  inc, dec, busy, done
  );

  modport slave (
    input  gamma_start, in_spike, out_spike, weight_in,
    output inc, dec, busy, done
  );

endinterface

// File: rtl/first_spike_latch.sv
// rtl/first_spike_latch.sv - records whether and when the first spike of a window arrived
//
// Purpose : flag + time stamp of the first spike seen while capture_en is high;
//           later spikes leave the stamp untouched until the next clear.
// Ports   : clk, rst_n (async active-low), clear, capture_en, spike, t[TS_W],
//           flag (out), stamp[TS_W] (out).
module first_spike_latch #(
  parameter int TS_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            capture_en,
  input  logic            spike,
  input  logic [TS_W-1:0] t,
  output logic            flag,
  output logic [TS_W-1:0] stamp
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag  <= 1'b0;
      stamp <= '0;
    end else if (clear) begin
      flag  <= 1'b0;
      stamp <= '0;
    end else if (capture_en && spike && !flag) begin
      flag  <= 1'b1;
      stamp <= t;
    end
  end

endmodule

// File: rtl/stdp_update_ctrl.sv
// rtl/stdp_update_ctrl.sv - STDP weight-update sequencer for one neuron's synapse bank
//
// Purpose : captures first-spike times of all inputs and the neuron output over a
//           GAMMA_LEN-cycle window, then walks the synapses one per cycle issuing
//           at most one registered inc or dec pulse each, with wrap-around guards.
// Ports   : clk, rst_n (async active-low), bus (stdp_update_ctrl_if.slave):
//           gamma_start, in_spike, out_spike, weight_in in; inc, dec, busy, done out.
// Build   : STDP_SILENT_DEPRESS_EN - synapses that never spiked while the neuron
//           fired are depressed (zero-guarded) instead of left alone.
module stdp_update_ctrl
  import stdp_pkg::*;
#(
  parameter int NUM_SYN   = 8,
  parameter int WEIGHT_W  = 3,
  parameter int GAMMA_LEN = 8
) (
  input logic               clk,
  input logic               rst_n,
  stdp_update_ctrl_if.slave bus
);

  localparam int TS_W  = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
  // One extra index value gives the drain cycle in which the last pulse is visible.
  localparam int IDX_W = $clog2(NUM_SYN + 1);
  localparam logic [WEIGHT_W-1:0] W_MAX = WEIGHT_W'(max_weight(WEIGHT_W));

  state_t state, state_nx;

  logic [TS_W-1:0]  t;
  logic [IDX_W-1:0] idx;

  logic               clear;
  logic               capture_en;
  logic [NUM_SYN-1:0] flag_in;
  logic [TS_W-1:0]    t_in [NUM_SYN];
  logic               flag_out;
  logic [TS_W-1:0]    t_out;

  logic [NUM_SYN-1:0]  onehot;
  logic                sel_flag;
  logic [TS_W-1:0]     sel_t;
  logic [WEIGHT_W-1:0] sel_w;
  upd_t                decision;
  logic                pot_ok;
  logic                dep_ok;

  logic [NUM_SYN-1:0] inc_q;
  logic [NUM_SYN-1:0] dec_q;

  assign clear      = (state == IDLE) && bus.gamma_start;
  assign capture_en = (state == CAPTURE);

  for (genvar g = 0; g < NUM_SYN; g++) begin : g_in_latch
    first_spike_latch #(.TS_W(TS_W)) u_in (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .capture_en(capture_en),
      .spike     (bus.in_spike[g]),
      .t         (t),
      .flag      (flag_in[g]),
      .stamp     (t_in[g])
    );
  end

  first_spike_latch #(.TS_W(TS_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .capture_en(capture_en),
    .spike     (bus.out_spike),
    .t         (t),
    .flag      (flag_out),
    .stamp     (t_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.gamma_start) state_nx = CAPTURE;
      CAPTURE: if (t == TS_W'(GAMMA_LEN - 1)) state_nx = UPDATE;
      UPDATE:  if (idx == IDX_W'(NUM_SYN)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t   <= '0;
      idx <= '0;
    end else begin
      t   <= (state == CAPTURE) ? t + 1'b1 : '0;
      idx <= (state == UPDATE) ? idx + 1'b1 : '0;
    end
  end

  // Select the synapse under evaluation; onehot stays zero on the drain cycle.
  always_comb begin
    onehot   = '0;
    sel_flag = 1'b0;
    sel_t    = '0;
    sel_w    = '0;
    for (int i = 0; i < NUM_SYN; i++) begin
      if (idx == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        sel_flag  = flag_in[i];
        sel_t     = t_in[i];
        sel_w     = bus.weight_in[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  // Input at or before the output spike is causal; an input with no output
  // spike at all, or after it, is anti-causal.
  always_comb begin
    decision = NONE;
    if (sel_flag) begin
      decision = (flag_out && (sel_t <= t_out)) ? POT : DEP;
    end
`ifdef STDP_SILENT_DEPRESS_EN
    else if (flag_out) begin
      decision = DEP;
    end
`endif
  end

  assign pot_ok = (state == UPDATE) && (decision == POT) && (sel_w != W_MAX);
  assign dep_ok = (state == UPDATE) && (decision == DEP) && (sel_w != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= '0;
      dec_q <= '0;
    end else begin
      inc_q <= pot_ok ? onehot : '0;
      dec_q <= dep_ok ? onehot : '0;
    end
  end

  assign bus.inc  = inc_q;
  assign bus.dec  = dec_q;
  assign bus.busy = (state == CAPTURE) || (state == UPDATE);
  assign bus.done = (state == DONE);

endmodule
